// File: rtl/binary_mul_arbiter_if.sv
// ============================================================================
//  Module   : binary_mul_arbiter_if
//  Brief    : Requester, multiplier and response signals of the shared
//             multiplier arbiter, with arbiter-side and environment-side views.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface binary_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 9
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_en;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_p;
    logic [IDW-1:0]    rsp_id;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_p, rsp_id
    );

    // Requesters, multiplier and consumer side
    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_p, rsp_id
    );
endinterface

`default_nettype wire

// File: rtl/binary_mul_arbiter.sv
// ============================================================================
//  Module   : binary_mul_arbiter
//  Brief    : Round-robin arbiter sharing one registered WxW multiplier among
//             NREQ requesters; one transaction in flight at a time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    binary_mul_arbiter_if.slave  bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_gnt;
    logic [W-1:0]      r_mul_a;
    logic [W-1:0]      r_mul_b;
    logic              r_rsp_valid;
    logic [2*W-1:0]    r_rsp_p;
    logic [IDW-1:0]    r_rsp_id;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_any;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_win;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;
    logic [NREQ-1:0]   w_req_ready;
    logic              w_mul_en;

    // Rotate the valid vector so bit 0 is the requester at ptr; the first set
    // bit of the rotated vector is the round-robin winner's offset from ptr.
    assign w_dbl = {bus.req_valid, bus.req_valid};
    assign w_rot = NREQ'(w_dbl >> r_ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                w_off = IDW'(k);
            end
        end
    end

    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win   = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                               : IDW'(w_sum);
    assign w_sel_a = W'(bus.req_a >> (int'(w_win) * W));
    assign w_sel_b = W'(bus.req_b >> (int'(w_win) * W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_mul_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_req_ready = NREQ'(1) << r_gnt;
                w_mul_en    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win;
                        r_mul_a <= w_sel_a;
                        r_mul_b <= w_sel_b;
                    end
                end
                S_ISSUE: begin
                    r_ptr <= (r_gnt == IDW'(NREQ-1)) ? '0 : r_gnt + IDW'(1);
                end
                S_WAIT: begin
                    // Multiplier output register became valid at the ISSUE edge
                    r_rsp_p     <= bus.mul_p;
                    r_rsp_id    <= r_gnt;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mul_en    = w_mul_en;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_id    = r_rsp_id;
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_binary_mul_arbiter.sv
// ============================================================================
//  Module   : tb_binary_mul_arbiter
//  Brief    : Self-checking bench for binary_mul_arbiter with a transaction
//             level reference model and directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    binary_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) bus ();

    binary_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // Registered multiplier shared by all requesters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.mul_p <= '0;
        else if (bus.mul_en)
            bus.mul_p <= {{W{1'b0}}, bus.mul_a} * {{W{1'b0}}, bus.mul_b};
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // ---------------- reference model and per-cycle compare ----------------
    int cyc, idle_from, t_grant, m_ptr, m_w, exp_id, exp_p;
    int ngrant = 0;
    int nrsp   = 0;
    bit inflight, m_exp_rdy, m_exp_rv;
    logic [NREQ-1:0] pv_valid, pv_ready;
    logic [W-1:0]    pv_a [NREQ];
    logic [W-1:0]    pv_b [NREQ];

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = -1; idle_from = 0; inflight = 0; m_ptr = 0;
            pv_valid = '0; pv_ready = '0;
        end else begin
            cyc++;
            for (int i = 0; i < NREQ; i++)
                if (pv_valid[i] && !pv_ready[i])
                    assert (bus.req_valid[i]) else $error("request %0d withdrawn before ready", i);

            // A grant shows as ready the cycle after an idle cycle with requests
            m_exp_rdy = !inflight && (cyc - 1 >= idle_from) && (pv_valid != '0);
            if (m_exp_rdy) begin
                m_w = rr_pick(m_ptr, pv_valid);
                chk("grant", bus.req_ready, 1 << m_w);
                chk("mul_en", bus.mul_en, 1);
                chk("mul_a", bus.mul_a, pv_a[m_w]);
                chk("mul_b", bus.mul_b, pv_b[m_w]);
                inflight = 1; t_grant = cyc; exp_id = m_w;
                exp_p  = int'(pv_a[m_w]) * int'(pv_b[m_w]);
                m_ptr  = (m_w + 1) % NREQ;
                ngrant++;
            end else begin
                chk("no_grant", bus.req_ready, 0);
                chk("mul_en_low", bus.mul_en, 0);
            end
            m_exp_rv = inflight && (cyc >= t_grant + 2);
            chk("rsp_valid", bus.rsp_valid, m_exp_rv);
            if (m_exp_rv) begin
                chk("rsp_p", bus.rsp_p, exp_p);
                chk("rsp_id", bus.rsp_id, exp_id);
            end
            chk("busy", busy, inflight);
            if (m_exp_rv && bus.rsp_ready) begin
                inflight = 0; idle_from = cyc + 1; nrsp++;
            end
            pv_valid = bus.req_valid;
            pv_ready = bus.req_ready;
            for (int i = 0; i < NREQ; i++) begin
                pv_a[i] = bus.req_a[i*W +: W];
                pv_b[i] = bus.req_b[i*W +: W];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int q    [NREQ];
    int e_id [5];
    int e_p  [5];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b);
        bus.req_a[i*W +: W] = W'(a);
        bus.req_b[i*W +: W] = W'(b);
        bus.req_valid[i]    = v;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_mul_en"},    bus.mul_en, 0);
        chk({tag, "_mul_a"},     bus.mul_a, 0);
        chk({tag, "_mul_b"},     bus.mul_b, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_p"},     bus.rsp_p, 0);
        chk({tag, "_rsp_id"},    bus.rsp_id, 0);
        chk({tag, "_busy"},      busy, 0);
    endtask

    // Lone request with rsp_ready high: ready at T+1, response at T+3
    task automatic one_shot(input int i, input int a, input int b, input int ep);
        tick(); set_req(i, 1'b1, a, b);
        @(negedge clk);
        @(negedge clk);
        chk("lat_ready", bus.req_ready[i], 1);
        tick(); bus.req_valid[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_rsp_valid", bus.rsp_valid, 1);
        chk("lit_rsp_p", bus.rsp_p, ep);
        chk("lit_rsp_id", bus.rsp_id, i);
        tick(); tick();
    endtask

    // Collect n responses against e_id/e_p; requester i drops after q[i] grants
    task automatic collect(input int n);
        int got = 0;
        int budget = 100;
        logic [NREQ-1:0] hs;
        while (got < n && budget > 0) begin
            @(negedge clk); budget--;
            hs = bus.req_valid & bus.req_ready;
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("col_rsp_id", bus.rsp_id, e_id[got]);
                chk("col_rsp_p", bus.rsp_p, e_p[got]);
                got++;
            end
            tick();
            for (int i = 0; i < NREQ; i++)
                if (hs[i]) begin
                    q[i]--;
                    if (q[i] == 0) bus.req_valid[i] = 1'b0;
                end
        end
        chk("col_count", got, n);
        tick();
    endtask

    function automatic int pick_op();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 511;
            3: return 256;
            default: return int'($urandom_range(0, 511));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget, issued, g0, r0;
        logic [NREQ-1:0] hs;
        bit seen;

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(); tick();

        // Single request and arithmetic corners
        one_shot(2, 511, 511, 261121);
        one_shot(0, 0, 300, 0);
        one_shot(1, 1, 257, 257);
        one_shot(3, 256, 2, 512);

        // Round-robin with everybody requesting; requester 0 asks twice
        tick();
        set_req(0, 1'b1, 2, 4);  set_req(1, 1'b1, 3, 5);
        set_req(2, 1'b1, 6, 7);  set_req(3, 1'b1, 10, 11);
        q[0] = 2; q[1] = 1; q[2] = 1; q[3] = 1;
        e_id[0] = 0; e_id[1] = 1; e_id[2] = 2; e_id[3] = 3; e_id[4] = 0;
        e_p[0]  = 8; e_p[1]  = 15; e_p[2] = 42; e_p[3] = 110; e_p[4] = 8;
        collect(5);

        // Back-pressure: response held for 10 cycles, req2 waits meanwhile
        tick();
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 12, 13); set_req(2, 1'b1, 17, 19);
        budget = 20; seen = 0;
        while (!seen && budget > 0) begin
            @(negedge clk); budget--;
            seen = bus.req_ready[1];
        end
        chk("bp_grant1", seen, 1);
        tick(); bus.req_valid[1] = 1'b0;
        budget = 20; seen = 0;
        while (!seen && budget > 0) begin
            @(negedge clk); budget--;
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_seen", seen, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.rsp_valid, 1);
            chk("bp_hold_p", bus.rsp_p, 156);
            chk("bp_hold_id", bus.rsp_id, 1);
            chk("bp_hold_busy", busy, 1);
            chk("bp_hold_noready", bus.req_ready, 0);
        end
        tick(); bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", bus.rsp_valid, 1);
        @(negedge clk);
        chk("bp_idle_noready", bus.req_ready, 0);
        @(negedge clk);
        chk("bp_next_grant", bus.req_ready, 4'b0100);
        tick(); bus.req_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_req2_p", bus.rsp_p, 323);
        chk("bp_req2_id", bus.rsp_id, 2);
        tick(); tick();

        // Asynchronous reset while the multiplier result is pending
        set_req(2, 1'b1, 20, 20);
        @(negedge clk);
        @(negedge clk);
        chk("ar_grant", bus.req_ready[2], 1);
        tick(); bus.req_valid[2] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        set_req(0, 1'b1, 7, 9); set_req(3, 1'b1, 4, 4);
        q[0] = 1; q[1] = 1; q[2] = 1; q[3] = 1;
        e_id[0] = 0; e_p[0] = 63; e_id[1] = 3; e_p[1] = 16;
        collect(2);

        // Random traffic with random consumer stalls
        g0 = ngrant; r0 = nrsp; issued = 0; budget = 40000;
        while ((issued < 2000 || bus.req_valid != '0 || inflight) && budget > 0) begin
            @(negedge clk); budget--;
            hs = bus.req_valid & bus.req_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && issued < 2000 && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'b1, pick_op(), pick_op());
                    issued++;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        bus.rsp_ready = 1'b1;
        chk("rand_issued", issued, 2000);
        chk("rand_grants", ngrant - g0, 2000);
        chk("rand_responses", nrsp - r0, ngrant - g0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/binary_mul_arbiter.md
Name: binary_mul_arbiter

Overview:
- Shares one registered 9x9 unsigned array multiplier among NREQ requesters.
- Each requester sends operands on a valid/ready handshake. The arbiter grants round-robin, drives the multiplier's A/B/en and waits out its one-cycle register latency. It then returns the 18-bit product with the winner's ID on a response handshake.
- Sits between the requester ports and the multiplier instance. It is the only driver of the multiplier's en.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID. Must satisfy 2^IDW >= NREQ.
- W, 9, operand width. Product width is 2*W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*W  packed multiplicands; requester i uses bits [i*W +: W]
- req_b  in  NREQ*W  packed multipliers, same packing
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- mul_a  out  W  to multiplier A
- mul_b  out  W  to multiplier B
- mul_en  out  1  to multiplier en
- mul_p  in  2W  from multiplier P (registered output)
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_p  out  2W  product
- rsp_id  out  IDW  ID of the requester the product belongs to
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, ptr=0, req_ready=0, mul_en=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE
  - req_ready=0.
  - If any req_valid is high, pick the winner g. g is the first set bit searched from ptr upward, wrapping modulo NREQ.
  - Register g, latch mul_a/mul_b from that requester's operands, go to ISSUE.
- ISSUE (one cycle)
  - req_ready[g]=1 combinationally; the handshake completes in this cycle.
  - mul_en=1. The multiplier captures the product at the end of this cycle.
  - Update ptr=(g+1) mod NREQ. Go to WAIT.
- WAIT (one cycle)
  - mul_en=0. The multiplier's P now holds the product.
  - Capture rsp_p<=mul_p and rsp_id<=g, set rsp_valid<=1, go to RESP.
- RESP
  - Hold rsp_valid, rsp_p and rsp_id stable until rsp_valid && rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
  - Back-pressure: only one transaction is ever in flight.
- Latency:
  - Request winning in IDLE cycle T: ready at T+1, rsp_valid at T+3.
  - Minimum request-to-request throughput is 4 cycles with rsp_ready tied high.
- Withdrawal: requesters must hold req_valid and operands until ready. If req_valid[g] drops between IDLE and ISSUE, the transaction still issues with the latched operands. This is illegal stimulus; the bench flags it with an assertion.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Simultaneous events:
  - rsp handshake in RESP and new requests: the new grant is decided in the following IDLE cycle, never in the same cycle.
  - Requester indices >= NREQ do not exist. ptr wraps NREQ-1 -> 0.
- Reset mid-operation:
  - All state clears immediately and any pending product is discarded.
  - mul_en=0, so the multiplier holds its value, or clears it if it shares rst_n.
- Arithmetic:
  - rsp_p is exactly mul_p, full 2W bits. No truncation or sign extension; all values are unsigned.

Test Plan:
- Single request: requester 2 issues A=9'd511, B=9'd511 with rsp_ready=1. Required: req_ready[2] one cycle later, rsp_valid 3 cycles after the request, rsp_p=18'd261121, rsp_id=2.
- Zero and one: (A=0,B=300) gives 0. (A=1,B=257) gives 257. (A=256,B=2) gives 512, exercising the MSB-only operand.
- Round-robin: all 4 requesters assert continuously with distinct operands. Required grant order 0,1,2,3,0. Each rsp_id matches its product, e.g. req1 A=3,B=5 -> rsp_p=15, id=1.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid. rsp_p and rsp_id stay stable, busy=1, no req_ready pulses. On release, the next grant follows one cycle after the handshake.
- Async reset: assert rst_n low during WAIT. All outputs go to 0 immediately, without waiting for a clock edge. After release, a new request A=7,B=9 returns 63 with rsp_id correct and ptr restarted at 0.
- Random: 2000 random requests with random rsp_ready. A scoreboard checks rsp_p==A*B per ID and no lost or duplicated transactions.
